// File: rtl/dmem_arbiter.sv
// dmem_arbiter
// Two-port arbiter in front of a single-ported data memory. One access is
// in flight at a time and takes three cycles: grant (IDLE->ACCESS), memory
// strobe (ACCESS->RESP), then completion (RESP->IDLE). The completion edge
// raises the owner's ack for one cycle and, for a read, loads its rdata.
// When both ports request on the same edge, the port that was not granted
// most recently wins.
//
// Ports
//   clk, reset             clock, asynchronous active-high reset
//   mX_req/wr/addr/wdata   request from port X (fields sampled at grant only)
//   mX_ack                 one-cycle completion pulse (registered)
//   mX_rdata               last read data returned to port X (registered)
//   busy                   an access is in flight
//   mem_addr/mem_wrData    latched address / write data towards the memory
//   mem_rdMem/mem_wrMem    memory strobes, high only in ACCESS
//   mem_rdData             memory read data, valid the cycle after mem_rdMem
module dmem_arbiter #(
    parameter int RESET_PRIO = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        m0_req,
    input  logic        m0_wr,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    output logic        m0_ack,
    output logic [31:0] m0_rdata,
    input  logic        m1_req,
    input  logic        m1_wr,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    output logic        m1_ack,
    output logic [31:0] m1_rdata,
    output logic        busy,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wrData,
    output logic        mem_rdMem,
    output logic        mem_wrMem,
    input  logic [31:0] mem_rdData
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        owner_q, owner_d;
    logic        wr_q, wr_d;
    logic        last_q, last_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        ack0_q, ack0_d;
    logic        ack1_q, ack1_d;
    logic [31:0] rdata0_q, rdata0_d;
    logic [31:0] rdata1_q, rdata1_d;
    logic        grant;

    // Port that would win if a grant happened this cycle. On a tie the
    // port that did not win last time is chosen.
    always_comb begin
        if (m0_req && m1_req) begin
            grant = ~last_q;
        end else begin
            grant = m1_req;
        end
    end

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        wr_d     = wr_q;
        last_d   = last_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        ack0_d   = 1'b0;
        ack1_d   = 1'b0;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;
        case (state_q)
            IDLE: begin
                if (m0_req || m1_req) begin
                    state_d = ACCESS;
                    owner_d = grant;
                    last_d  = grant;
                    wr_d    = grant ? m1_wr    : m0_wr;
                    addr_d  = grant ? m1_addr  : m0_addr;
                    wdata_d = grant ? m1_wdata : m0_wdata;
                end
            end
            ACCESS: state_d = RESP;
            RESP: begin
                state_d = IDLE;
                if (owner_q) begin
                    ack1_d = 1'b1;
                    if (!wr_q) rdata1_d = mem_rdData;
                end else begin
                    ack0_d = 1'b1;
                    if (!wr_q) rdata0_d = mem_rdData;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            owner_q  <= 1'b0;
            wr_q     <= 1'b0;
            // Pointer holds the "most recent" winner, so the opposite port
            // of RESET_PRIO is recorded to let RESET_PRIO win the first tie.
            last_q   <= (RESET_PRIO == 0);
            addr_q   <= '0;
            wdata_q  <= '0;
            ack0_q   <= 1'b0;
            ack1_q   <= 1'b0;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            wr_q     <= wr_d;
            last_q   <= last_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            ack0_q   <= ack0_d;
            ack1_q   <= ack1_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
        end
    end

    // Strobes are gated by reset too so they drop in the same instant
    // reset rises, without waiting for the state register to settle.
    assign mem_rdMem  = (state_q == ACCESS) && !wr_q && !reset;
    assign mem_wrMem  = (state_q == ACCESS) &&  wr_q && !reset;
    assign mem_addr   = addr_q;
    assign mem_wrData = wdata_q;
    assign busy       = (state_q != IDLE);
    assign m0_ack     = ack0_q;
    assign m1_ack     = ack1_q;
    assign m0_rdata   = rdata0_q;
    assign m1_rdata   = rdata1_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        req   [2];
    logic        wr    [2];
    logic [31:0] addr  [2];
    logic [31:0] wdata [2];
    logic        m0_ack, m1_ack, busy, mem_rdMem, mem_wrMem;
    logic [31:0] m0_rdata, m1_rdata, mem_addr, mem_wrData, mem_rdData;
    logic        m0_req, m1_req, m0_wr, m1_wr;
    logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;

    int total = 0;
    int bad   = 0;

    assign m0_req = req[0];   assign m1_req = req[1];
    assign m0_wr  = wr[0];    assign m1_wr  = wr[1];
    assign m0_addr = addr[0]; assign m1_addr = addr[1];
    assign m0_wdata = wdata[0]; assign m1_wdata = wdata[1];

    always #5 clk = ~clk;

    dmem_arbiter #(.RESET_PRIO(0)) dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_wr(m0_wr), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_ack(m0_ack), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_wr(m1_wr), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_ack(m1_ack), .m1_rdata(m1_rdata),
        .busy(busy), .mem_addr(mem_addr), .mem_wrData(mem_wrData),
        .mem_rdMem(mem_rdMem), .mem_wrMem(mem_wrMem), .mem_rdData(mem_rdData)
    );

    function automatic logic [31:0] memval(input logic [7:0] a);
        return {8'hC3, a, ~a, 8'h5A};
    endfunction

    // Data memory: registered read, reloaded with a known pattern on reset.
    logic [31:0] dmem [256];
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 256; i++) dmem[i] <= memval(8'(i));
            mem_rdData <= '0;
        end else begin
            if (mem_wrMem) dmem[mem_addr[7:0]] <= mem_wrData;
            if (mem_rdMem) mem_rdData <= dmem[mem_addr[7:0]];
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req[0] = 1'b0; req[1] = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // Drives one single access on port p and records what happened in the
    // three cycles after the grant edge (bit k = k-th cycle).
    task automatic access(input int p, input logic w, input logic [31:0] a,
                          input logic [31:0] d, output logic [2:0] ak0,
                          output logic [2:0] ak1, output logic [2:0] bz,
                          output logic [2:0] rds, output logic [2:0] wrs,
                          output logic [31:0] ad0);
        req[p] = 1'b1; wr[p] = w; addr[p] = a; wdata[p] = d;
        ad0 = '0;
        for (int k = 0; k < 3; k++) begin
            tick();
            ak0[k] = m0_ack; ak1[k] = m1_ack; bz[k] = busy;
            rds[k] = mem_rdMem; wrs[k] = mem_wrMem;
            if (k == 0) ad0 = mem_addr;
        end
        req[p] = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        for (int p = 0; p < 2; p++) begin
            req[p] = 1'b0; wr[p] = 1'b0; addr[p] = '0; wdata[p] = '0;
        end
        #3;
        total++;
        if ({busy, m0_ack, m1_ack, mem_rdMem, mem_wrMem} !== 5'b0) begin
            bad++;
            $display("FAIL reset_ctrl got=%b exp=00000",
                     {busy, m0_ack, m1_ack, mem_rdMem, mem_wrMem});
        end
        total++;
        if ({m0_rdata, m1_rdata, mem_addr, mem_wrData} !== 128'h0) begin
            bad++;
            $display("FAIL reset_data got=%h %h %h %h exp=0", m0_rdata, m1_rdata,
                     mem_addr, mem_wrData);
        end
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_m0_wr_rd();
        logic [2:0] ak0, ak1, bz, rds, wrs;
        logic [31:0] ad0;
        do_reset();
        access(0, 1'b1, 32'h5, 32'hDEADBEEF, ak0, ak1, bz, rds, wrs, ad0);
        total++;
        if ({ak0, ak1, bz, rds, wrs} !== {3'b100, 3'b000, 3'b011, 3'b000, 3'b001}) begin
            bad++;
            $display("FAIL m0_write_seq got ack0=%b ack1=%b busy=%b rd=%b wr=%b exp 100 000 011 000 001",
                     ak0, ak1, bz, rds, wrs);
        end
        total++;
        if (ad0 !== 32'h5) begin
            bad++; $display("FAIL m0_write_addr got=%h exp=5", ad0);
        end
        access(0, 1'b0, 32'h5, 32'h0, ak0, ak1, bz, rds, wrs, ad0);
        total++;
        if ({ak0, ak1, rds, wrs} !== {3'b100, 3'b000, 3'b001, 3'b000}) begin
            bad++;
            $display("FAIL m0_read_seq got ack0=%b ack1=%b rd=%b wr=%b exp 100 000 001 000",
                     ak0, ak1, rds, wrs);
        end
        total++;
        if (m0_rdata !== 32'hDEADBEEF) begin
            bad++; $display("FAIL m0_rdata got=%h exp=deadbeef", m0_rdata);
        end
    endtask

    task automatic test_tie();
        logic [5:0] a0, a1;
        logic [31:0] first_addr;
        do_reset();
        req[0] = 1'b1; wr[0] = 1'b0; addr[0] = 32'h7;
        req[1] = 1'b1; wr[1] = 1'b0; addr[1] = 32'h8;
        first_addr = '0;
        for (int k = 0; k < 6; k++) begin
            tick();
            a0[k] = m0_ack; a1[k] = m1_ack;
            if (k == 0) first_addr = mem_addr;
            if (m0_ack) req[0] = 1'b0;
            if (m1_ack) req[1] = 1'b0;
        end
        req[0] = 1'b0; req[1] = 1'b0;
        total++;
        if (first_addr !== 32'h7) begin
            bad++; $display("FAIL tie_first_grant got addr=%h exp=7", first_addr);
        end
        total++;
        if ({a0, a1} !== {6'b000100, 6'b100000}) begin
            bad++; $display("FAIL tie_ack_times got ack0=%b ack1=%b exp 000100 100000", a0, a1);
        end
        total++;
        if ({m0_rdata, m1_rdata} !== {memval(8'h7), memval(8'h8)}) begin
            bad++;
            $display("FAIL tie_rdata got=%h %h exp=%h %h", m0_rdata, m1_rdata,
                     memval(8'h7), memval(8'h8));
        end
    endtask

    task automatic test_back_to_back();
        logic e0, e1;
        do_reset();
        req[0] = 1'b1; wr[0] = 1'b0; addr[0] = 32'hA;
        req[1] = 1'b1; wr[1] = 1'b0; addr[1] = 32'hB;
        for (int k = 0; k < 12; k++) begin
            tick();
            e0 = (k % 3 == 2) && ((k / 3) % 2 == 0);
            e1 = (k % 3 == 2) && ((k / 3) % 2 == 1);
            total++;
            if ({m0_ack, m1_ack} !== {e0, e1}) begin
                bad++;
                $display("FAIL b2b_ack k=%0d got=%b%b exp=%b%b", k, m0_ack, m1_ack, e0, e1);
            end
        end
        req[0] = 1'b0; req[1] = 1'b0;
        total++;
        if ({m0_rdata, m1_rdata} !== {memval(8'hA), memval(8'hB)}) begin
            bad++; $display("FAIL b2b_rdata got=%h %h", m0_rdata, m1_rdata);
        end
    endtask

    task automatic test_addr_change();
        do_reset();
        req[0] = 1'b1; wr[0] = 1'b0; addr[0] = 32'h5;
        for (int k = 0; k < 3; k++) begin
            tick();
            if (k == 0) addr[0] = 32'h9;
            if (k < 2) begin
                total++;
                if (mem_addr !== 32'h5 || mem_rdMem !== (k == 0)) begin
                    bad++;
                    $display("FAIL addr_hold k=%0d got addr=%h rd=%b exp addr=5 rd=%b",
                             k, mem_addr, mem_rdMem, (k == 0));
                end
            end
        end
        req[0] = 1'b0;
        total++;
        if (m0_ack !== 1'b1 || m0_rdata !== memval(8'h5)) begin
            bad++;
            $display("FAIL addr_hold_rdata got ack=%b rdata=%h exp ack=1 rdata=%h",
                     m0_ack, m0_rdata, memval(8'h5));
        end
    endtask

    task automatic test_reset_midaccess();
        do_reset();
        req[0] = 1'b1; wr[0] = 1'b1; addr[0] = 32'h4; wdata[0] = 32'hCAFEF00D;
        tick();
        total++;
        if (mem_wrMem !== 1'b1 || busy !== 1'b1) begin
            bad++; $display("FAIL midrst_pre got wr=%b busy=%b exp 1 1", mem_wrMem, busy);
        end
        #2;
        reset = 1'b1;
        #1;
        total++;
        if ({mem_wrMem, mem_rdMem, busy, m0_ack, m1_ack} !== 5'b0) begin
            bad++;
            $display("FAIL midrst_async got=%b exp=00000",
                     {mem_wrMem, mem_rdMem, busy, m0_ack, m1_ack});
        end
        @(posedge clk);
        #1;
        total++;
        if ({busy, m0_ack, m1_ack} !== 3'b0) begin
            bad++; $display("FAIL midrst_hold got=%b exp=000", {busy, m0_ack, m1_ack});
        end
        reset = 1'b0;
        // req[0] is still pending and must be granted afresh.
        for (int k = 0; k < 3; k++) begin
            tick();
            total++;
            if ({busy, m0_ack, m1_ack} !== {(k < 2), (k == 2), 1'b0}) begin
                bad++;
                $display("FAIL midrst_replay k=%0d got=%b exp=%b", k,
                         {busy, m0_ack, m1_ack}, {(k < 2), (k == 2), 1'b0});
            end
        end
        req[0] = 1'b0;
    endtask

    task automatic test_m1_wr_rd();
        logic [2:0] ak0, ak1, bz, rds, wrs;
        logic [31:0] ad0;
        do_reset();
        access(1, 1'b0, 32'h2, 32'h0, ak0, ak1, bz, rds, wrs, ad0);
        total++;
        if (m1_rdata !== memval(8'h2) || ak1 !== 3'b100) begin
            bad++; $display("FAIL m1_first_read got rdata=%h ack=%b", m1_rdata, ak1);
        end
        access(1, 1'b1, 32'h3, 32'h12345678, ak0, ak1, bz, rds, wrs, ad0);
        total++;
        if (ak1 !== 3'b100 || ak0 !== 3'b000 || wrs !== 3'b001) begin
            bad++; $display("FAIL m1_write_seq got ack1=%b ack0=%b wr=%b", ak1, ak0, wrs);
        end
        total++;
        if (m1_rdata !== memval(8'h2)) begin
            bad++; $display("FAIL m1_rdata_after_write got=%h exp=%h", m1_rdata, memval(8'h2));
        end
        access(1, 1'b0, 32'h3, 32'h0, ak0, ak1, bz, rds, wrs, ad0);
        total++;
        if (m1_rdata !== 32'h12345678) begin
            bad++; $display("FAIL m1_rdata_after_read got=%h exp=12345678", m1_rdata);
        end
    endtask

    // Transaction-level reference: a grant may happen on any edge where no
    // access is outstanding; it completes two edges later.
    task automatic test_random();
        logic [31:0] rmem [256];
        logic        g_valid, g_port, g_wr, last, gfree, in_acc;
        logic [31:0] g_addr, g_wdata, lat_addr, lat_wdata;
        logic [31:0] exp_rd [2];
        logic        ea [2];
        logic        r [2];
        int          g_cyc;
        do_reset();
        for (int i = 0; i < 256; i++) rmem[i] = memval(8'(i));
        g_valid = 1'b0; g_port = 1'b0; g_wr = 1'b0; g_cyc = 0;
        g_addr = '0; g_wdata = '0;
        last = 1'b1;
        exp_rd[0] = '0; exp_rd[1] = '0;
        lat_addr = '0; lat_wdata = '0;
        for (int c = 0; c < 600; c++) begin
            @(posedge clk);
            r[0] = req[0]; r[1] = req[1];
            ea[0] = 1'b0; ea[1] = 1'b0;
            gfree = !g_valid;
            if (g_valid && c == g_cyc + 2) begin
                ea[g_port] = 1'b1;
                if (!g_wr) exp_rd[g_port] = rmem[g_addr[7:0]];
                g_valid = 1'b0;
            end
            if (gfree && (r[0] || r[1])) begin
                g_port  = (r[0] && r[1]) ? !last : r[1];
                last    = g_port;
                g_valid = 1'b1;
                g_cyc   = c;
                g_wr    = wr[g_port];
                g_addr  = addr[g_port];
                g_wdata = wdata[g_port];
                lat_addr = g_addr; lat_wdata = g_wdata;
                if (g_wr) rmem[g_addr[7:0]] = g_wdata;
            end
            in_acc = g_valid && (c == g_cyc);
            #1;
            total++;
            if ({m0_ack, m1_ack, busy, mem_rdMem, mem_wrMem} !==
                {ea[0], ea[1], g_valid, in_acc && !g_wr, in_acc && g_wr}) begin
                bad++;
                $display("FAIL rnd_ctrl c=%0d got=%b exp=%b", c,
                         {m0_ack, m1_ack, busy, mem_rdMem, mem_wrMem},
                         {ea[0], ea[1], g_valid, in_acc && !g_wr, in_acc && g_wr});
            end
            total++;
            if (m0_rdata !== exp_rd[0]) begin
                bad++; $display("FAIL rnd_rdata0 c=%0d got=%h exp=%h", c, m0_rdata, exp_rd[0]);
            end
            total++;
            if (m1_rdata !== exp_rd[1]) begin
                bad++; $display("FAIL rnd_rdata1 c=%0d got=%h exp=%h", c, m1_rdata, exp_rd[1]);
            end
            total++;
            if (mem_addr !== lat_addr || mem_wrData !== lat_wdata) begin
                bad++;
                $display("FAIL rnd_membus c=%0d got=%h/%h exp=%h/%h", c, mem_addr,
                         mem_wrData, lat_addr, lat_wdata);
            end
            for (int p = 0; p < 2; p++) begin
                if (ea[p]) begin
                    // Usually drop; sometimes keep req to issue a new access.
                    if ($urandom_range(0, 3) != 0) req[p] = 1'b0;
                end else if (!req[p]) begin
                    if ($urandom_range(0, 2) != 0) begin
                        req[p] = 1'b1;
                        wr[p] = 1'($urandom_range(0, 1));
                        addr[p] = 32'($urandom_range(0, 15));
                        wdata[p] = $urandom;
                    end
                end else if (g_valid && g_port == 1'(p)) begin
                    // Owner's fields were captured at grant; scramble them.
                    wr[p] = 1'($urandom_range(0, 1));
                    addr[p] = 32'($urandom_range(0, 15));
                    wdata[p] = $urandom;
                end
            end
        end
        req[0] = 1'b0; req[1] = 1'b0;
        repeat (4) tick();
    endtask

    initial begin
        test_reset();
        test_m0_wr_rd();
        test_tie();
        test_back_to_back();
        test_addr_change();
        test_reset_midaccess();
        test_m1_wr_rd();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
